// File: rtl/cordic_pkg.sv
// Purpose    : shared constants and types for the sequential CORDIC engine.
// Latency    : n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
// Contents   : q2_30_t, state_t, K_Q30, PI_2_Q30, atan_q30() lookup.
package cordic_pkg;

    typedef logic signed [31:0] q2_30_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reciprocal of the CORDIC gain, so x converges directly to cos().
    localparam q2_30_t K_Q30    = 32'sh26DD3B6A;
    localparam q2_30_t PI_2_Q30 = 32'sh6487ED51;

    // atan(2^-i) * 2^30, rounded to nearest.
    function automatic q2_30_t atan_q30(input logic [4:0] idx);
        q2_30_t v;
        case (idx)
            5'd0:    v = 32'sh3243F6A9;
            5'd1:    v = 32'sh1DAC6705;
            5'd2:    v = 32'sh0FADBAFD;
            5'd3:    v = 32'sh07F56EA7;
            5'd4:    v = 32'sh03FEAB77;
            5'd5:    v = 32'sh01FFD55C;
            5'd6:    v = 32'sh00FFFAAB;
            5'd7:    v = 32'sh007FFF55;
            5'd8:    v = 32'sh003FFFEB;
            5'd9:    v = 32'sh001FFFFD;
            5'd10:   v = 32'sh00100000;
            5'd11:   v = 32'sh00080000;
            5'd12:   v = 32'sh00040000;
            5'd13:   v = 32'sh00020000;
            5'd14:   v = 32'sh00010000;
            5'd15:   v = 32'sh00008000;
            5'd16:   v = 32'sh00004000;
            5'd17:   v = 32'sh00002000;
            5'd18:   v = 32'sh00001000;
            5'd19:   v = 32'sh00000800;
            5'd20:   v = 32'sh00000400;
            5'd21:   v = 32'sh00000200;
            5'd22:   v = 32'sh00000100;
            5'd23:   v = 32'sh00000080;
            5'd24:   v = 32'sh00000040;
            5'd25:   v = 32'sh00000020;
            5'd26:   v = 32'sh00000010;
            5'd27:   v = 32'sh00000008;
            5'd28:   v = 32'sh00000004;
            5'd29:   v = 32'sh00000002;
            5'd30:   v = 32'sh00000001;
            default: v = 32'sh00000000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// Purpose    : one combinational CORDIC micro-rotation (rotation mode).
// Latency    : 0 cycles, purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports      : i_x/i_y/i_z current vector and angle, i_shift iteration index,
//              i_atan angle constant for that index; o_x/o_y/o_z rotated values.
module cordic_stage #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_y,
    input  logic signed [WIDTH-1:0] i_z,
    input  logic        [4:0]       i_shift,
    input  logic signed [WIDTH-1:0] i_atan,
    output logic signed [WIDTH-1:0] o_x,
    output logic signed [WIDTH-1:0] o_y,
    output logic signed [WIDTH-1:0] o_z
);

    logic                    w_dir_pos;
    logic signed [WIDTH-1:0] w_x_sh;
    logic signed [WIDTH-1:0] w_y_sh;

    // z == 0 rotates in the positive direction.
    assign w_dir_pos = ~i_z[WIDTH-1];
    assign w_x_sh    = i_x >>> i_shift;
    assign w_y_sh    = i_y >>> i_shift;

    // Plain wrapping adds: in-range angles never overflow Q2.30.
    assign o_x = w_dir_pos ? (i_x - w_y_sh) : (i_x + w_y_sh);
    assign o_y = w_dir_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);
    assign o_z = w_dir_pos ? (i_z - i_atan) : (i_z + i_atan);

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Purpose    : iterative CORDIC cos/sin engine, one shared stage reused per cycle.
// Latency    : ITERATIONS cycles from the load edge to out_valid; one result per ITERATIONS+2 cycles.
// Backpressure: out_ready=0 holds DONE and its outputs; no angle is accepted outside IDLE.
// Ports      : clk/rst_n (async active-low); in_valid/in_ready/in_angle request side;
//              out_valid/out_ready/out_cos/out_sin/out_theta/out_range_err result side; busy.
// Option     : define CORDIC_ITER_TRACE_EN to add trace_valid/trace_idx/trace_x/trace_z,
//              which expose the pre-rotation state of every ITER cycle.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 30,
    parameter int ITERATIONS = 30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_angle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_cos,
    output logic signed [WIDTH-1:0] out_sin,
    output logic signed [WIDTH-1:0] out_theta,
    output logic                    out_range_err,
    output logic                    busy
`ifdef CORDIC_ITER_TRACE_EN
    ,
    output logic                    trace_valid,
    output logic        [4:0]       trace_idx,
    output logic signed [WIDTH-1:0] trace_x,
    output logic signed [WIDTH-1:0] trace_z
`endif
);

    // Package constants are Q2.30; rescale them to the configured FRAC.
    localparam int FSH = 30 - FRAC;
    localparam logic signed [WIDTH-1:0] K_W    = WIDTH'(K_Q30 >>> FSH);
    localparam logic signed [WIDTH-1:0] PI_2_W = WIDTH'(PI_2_Q30 >>> FSH);
    localparam logic        [4:0]       LAST   = 5'(ITERATIONS - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic        [4:0]       r_cnt;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] r_z;
    logic signed [WIDTH-1:0] r_angle;
    logic                    r_err;

    logic                    w_load;
    logic                    w_last;
    logic                    w_range_err;
    logic signed [WIDTH-1:0] w_atan;
    logic signed [WIDTH-1:0] w_x_nxt;
    logic signed [WIDTH-1:0] w_y_nxt;
    logic signed [WIDTH-1:0] w_z_nxt;

    assign w_load      = (r_state == IDLE) && in_valid;
    assign w_last      = (r_cnt == LAST);
    // Signed compare on both sides avoids the |0x80000000| overflow trap.
    assign w_range_err = (in_angle > PI_2_W) || (in_angle < -PI_2_W);
    assign w_atan      = WIDTH'(atan_q30(r_cnt) >>> FSH);

    cordic_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_shift (r_cnt),
        .i_atan  (w_atan),
        .o_x     (w_x_nxt),
        .o_y     (w_y_nxt),
        .o_z     (w_z_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = ITER;
            ITER:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake / status outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load in IDLE, rotate in ITER, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_angle <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_x     <= K_W;
            r_y     <= '0;
            r_z     <= in_angle;
            r_angle <= in_angle;
            r_err   <= w_range_err;
        end else if (r_state == ITER) begin
            r_cnt <= r_cnt + 5'd1;
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_z   <= w_z_nxt;
        end
    end

    // Out-of-range requests still rotate, but the result is replaced by
    // zeros and the original angle so the sink can see what was rejected.
    assign out_cos       = r_err ? '0      : r_x;
    assign out_sin       = r_err ? '0      : r_y;
    assign out_theta     = r_err ? r_angle : r_z;
    assign out_range_err = r_err;

`ifdef CORDIC_ITER_TRACE_EN
    assign trace_valid = (r_state == ITER);
    assign trace_idx   = r_cnt;
    assign trace_x     = r_x;
    assign trace_z     = r_z;
`endif

endmodule
